// File: rtl/ysyx_24080014_lsu.sv
// Multi-cycle load/store unit: one op at a time, valid/ready memory bus, load align/extend, GPR write pulse.
// Optional response timeout enabled by defining YSYX_24080014_LSU_TIMEOUT_EN.
module ysyx_24080014_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        mem_rsp_ready,
    output logic        wb_RegWr,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_rd_data,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the requester holds every request field stable from valid rising until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_done;
    logic        r_err;
    logic        r_regwr;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  r_cnt;
`endif

    logic        w_ld_illegal;
    logic        w_st_illegal;
    logic        w_misalign;
    logic        w_bad;
    logic [4:0]  w_shamt;
    logic [31:0] w_rsh;
    logic [31:0] w_load;

    assign w_ld_illegal = !ex_is_store && ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11));
    assign w_st_illegal = ex_is_store && (ex_funct3[2] || (ex_funct3[1:0] == 2'b11));
    assign w_misalign   = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                          ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    assign w_bad        = w_ld_illegal || w_st_illegal || w_misalign;

    assign w_shamt = {r_addr[1:0], 3'b000};
    assign w_rsh   = mem_rsp_rdata >> w_shamt;

    always_comb begin
        w_load = w_rsh;
        case (r_funct3)
            3'b000:  w_load = {{24{w_rsh[7]}}, w_rsh[7:0]};
            3'b100:  w_load = {24'd0, w_rsh[7:0]};
            3'b001:  w_load = {{16{w_rsh[15]}}, w_rsh[15:0]};
            3'b101:  w_load = {16'd0, w_rsh[15:0]};
            default: w_load = w_rsh;
        endcase
    end

    always_comb begin
        mem_req_wmask = 4'b0000;
        if (r_is_store) begin
            case (r_funct3[1:0])
                2'b00:   mem_req_wmask = 4'b0001 << r_addr[1:0];
                2'b01:   mem_req_wmask = 4'b0011 << r_addr[1:0];
                default: mem_req_wmask = 4'b1111;
            endcase
        end
    end

    assign ex_ready      = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = {r_addr[31:2], 2'b00};
    assign mem_req_wen   = r_is_store;
    assign mem_req_wdata = r_wdata << w_shamt;
    assign mem_rsp_ready = (r_state == S_RSP);
    assign wb_RegWr      = r_regwr;
    assign wb_rd         = r_wb_rd;
    assign wb_rd_data    = r_wb_data;
    assign lsu_done      = r_done;
    assign lsu_err       = r_err;
    assign dbg_state     = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 5'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_regwr    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
            r_cnt      <= 8'd0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_regwr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid) begin
                        r_is_store <= ex_is_store;
                        r_funct3   <= ex_funct3;
                        r_addr     <= ex_addr;
                        r_wdata    <= ex_wdata;
                        r_rd       <= ex_rd;
                        // Rejected ops never touch the bus; report and stay ready.
                        if (w_bad) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_RSP;
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
                        r_cnt   <= 8'd0;
`endif
                    end
                end
                S_RSP: begin
                    if (mem_rsp_valid) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        if (!r_is_store && (r_rd != 5'd0)) begin
                            r_regwr   <= 1'b1;
                            r_wb_rd   <= r_rd;
                            r_wb_data <= w_load;
                        end
`ifdef YSYX_24080014_LSU_TIMEOUT_EN
                    end else if (r_cnt == LP_TO_LAST) begin
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_24080014_lsu.md
# ysyx_24080014_lsu

Multi-cycle load/store unit between the execute stage and the general register file write port. Accepts one memory operation at a time from execute, drives a valid/ready request/response memory bus, aligns and extends load data, and emits a one-cycle register write (RegWr/rd/rd_data) toward the GPR block. Also reports completion and access errors (misalignment, illegal width, optional response timeout) so the core can advance the PC or trap.

## Interface
- TIMEOUT_CYCLES, 255: response-wait limit in cycles (used only with the timeout macro); 8-bit counter, legal range 1..255.

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  execute presents a memory op
- ex_ready  out  1  LSU can accept (high only in IDLE)
- ex_is_store  in  1  1 = store, 0 = load
- ex_funct3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- ex_addr  in  32  byte address
- ex_wdata  in  32  store data (rs2 value)
- ex_rd  in  5  load destination index
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  32  lane-shifted store data
- mem_req_wmask  out  4  byte-enable mask (0 for loads)
- mem_rsp_valid  in  1  response/write-ack valid
- mem_rsp_rdata  in  32  read word
- mem_rsp_ready  out  1  high only in RSP
- wb_RegWr  out  1  one-cycle register write pulse
- wb_rd  out  5  write index
- wb_rd_data  out  32  aligned, extended load value
- lsu_done  out  1  one-cycle completion pulse (success or error)
- lsu_err  out  1  one-cycle error pulse, coincident with lsu_done

## Operation
- States: IDLE, REQ, RSP. Reset → IDLE.
- IDLE: ex_ready=1. On ex_valid: latch is_store, funct3, addr, wdata, rd. If op illegal or misaligned → stay IDLE, next cycle lsu_done=lsu_err=1, no bus request. Else → REQ.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0. Illegal: load funct3 011/110/111; store funct3 ≥011.
- REQ: mem_req_valid=1, fields stable until mem_req_ready; on handshake → RSP.
- RSP: mem_rsp_ready=1; on mem_rsp_valid → IDLE, next cycle lsu_done=1; loads also assert wb_RegWr unless rd=0.
- Store encoding: off=addr[1:0]; wdata = ex_wdata << 8·off; wmask SB 0001<<off, SH 0011<<off, SW 1111.
- Load extraction: v = rdata >> 8·off; B sign-extend v[7:0], BU zero-extend v[7:0], H/HU v[15:0] sign/zero, W v.
- mem_rsp_valid outside RSP ignored. ex_valid outside IDLE ignored (ex_ready=0).

## Timing
- All outputs registered except ex_ready, mem_req_*, mem_rsp_ready (decoded from state and latched fields).
- Reset values: every output 0 except ex_ready=1; counter 0.
- Best-case latency: accept at cycle T, request T+1, response T+2, lsu_done/wb_RegWr at T+3; new op acceptable at T+3.
- Error path: accept at T, lsu_done=lsu_err=1 at T+1.
- wb_RegWr, lsu_done, lsu_err are single-cycle pulses.
- Async reset mid-operation: immediately IDLE, outputs to reset values; an in-flight response arriving after reset is dropped.

## Configuration
- YSYX_24080014_LSU_TIMEOUT_EN defined: counter clears on entering RSP, increments each RSP cycle without mem_rsp_valid; at count == TIMEOUT_CYCLES → IDLE, next cycle lsu_done=lsu_err=1, no RegWr. Response and timeout in the same cycle: response wins.
- Undefined: no counter; RSP waits indefinitely; lsu_err only from misalignment/illegal op.

## Test plan
- LB addr 0x80000003, rdata 0x80FF_1234 → wb_rd_data 0xFFFFFF80, wb_RegWr=1, lsu_done at T+3 with zero-wait memory.
- LHU addr 0x80000002, rdata 0xBEEF_0000 → wb_rd_data 0x0000BEEF; same with LH → 0xFFFFBEEF.
- SB addr 0x80000001, wdata 0x000000AB → mem_req_wdata 0x0000AB00, wmask 0010, wen=1; lsu_done, wb_RegWr=0.
- LW addr 0x80000002 → no mem_req_valid, lsu_done=lsu_err=1 at T+1; LW to rd=0 with valid rsp → wb_RegWr=0.
- mem_req_ready low 4 cycles then rsp 3 cycles later → request fields stable throughout, single done pulse; rst_n low during RSP → IDLE, late rsp ignored.
- With YSYX_24080014_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no rsp → lsu_err pulse 8 cycles after entering RSP; rsp on cycle 8 → normal completion.
